ppu_bg_fetcher: RTL

Background tile fetcher for one PPU scanline.
- Drives the PPU read bus (ppu_ab) into the CHR ROM/VRAM path and consumes ppu_do.
- Runs the NES 8-cycle fetch order: nametable, attribute, pattern low, pattern high.
- Fills 16-bit shift registers and streams 256 background pixels, each a 4-bit {palette, pattern} value, to the pixel mux downstream.

---
 rtl/ppu_pkg.sv | 56 +++++
 rtl/ppu_bg_shifter.sv | 27 ++
 rtl/ppu_bg_fetcher.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types, bus constants and loopy-v helpers for the PPU background path.
package ppu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        RENDER  = 2'd2
    } bg_state_t;

    localparam logic [15:0] NT_BASE = 16'h2000;
    localparam logic [15:0] AT_BASE = 16'h23C0;

    // Loopy v field positions
    localparam int V_COARSE_X_LSB = 0;
    localparam int V_COARSE_X_MSB = 4;
    localparam int V_COARSE_Y_LSB = 5;
    localparam int V_COARSE_Y_MSB = 9;
    localparam int V_NT_LSB       = 10;
    localparam int V_NT_MSB       = 11;
    localparam int V_FINE_Y_LSB   = 12;
    localparam int V_FINE_Y_MSB   = 14;

    function automatic logic [15:0] nt_addr(input logic [14:0] v);
        return NT_BASE | {4'b0, v[V_NT_MSB:0]};
    endfunction

    function automatic logic [15:0] at_addr(input logic [14:0] v);
        return AT_BASE | {4'b0, v[V_NT_MSB:V_NT_LSB], 4'b0,
                          v[V_COARSE_Y_MSB -: 3], v[V_COARSE_X_MSB -: 3]};
    endfunction

    function automatic logic [15:0] pt_addr(input logic table_sel, input logic [7:0] id,
                                            input logic plane, input logic [14:0] v);
        return {3'b0, table_sel, id, plane, v[V_FINE_Y_MSB:V_FINE_Y_LSB]};
    endfunction

    // Quadrant inside the 32x32 attribute cell picks which 2-bit palette field applies
    function automatic logic [1:0] at_select(input logic [7:0] at, input logic [14:0] v);
        logic [2:0] sh;
        sh = {v[V_COARSE_Y_LSB + 1], v[V_COARSE_X_LSB + 1], 1'b0};
        return at[sh +: 2];
    endfunction

    function automatic logic [14:0] coarse_x_inc(input logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (v[V_COARSE_X_MSB:V_COARSE_X_LSB] == 5'd31) begin
            r[V_COARSE_X_MSB:V_COARSE_X_LSB] = 5'd0;
            r[V_NT_LSB] = ~v[V_NT_LSB];
        end else begin
            r[V_COARSE_X_MSB:V_COARSE_X_LSB] = v[V_COARSE_X_MSB:V_COARSE_X_LSB] + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// One 16-bit background shift register: byte load into the low half, shift left otherwise.
module ppu_bg_shifter
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        preload,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 16'd0;
        end else if (load && preload) begin
            q <= {q[7:0], din};
        end else if (load) begin
            // Shift and reload land in the same cycle while pixels are streaming
            q <= {q[14:7], din};
        end else if (shift) begin
            q <= {q[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/ppu_bg_fetcher.sv
// Background tile fetcher: 8-cycle NT/AT/PT fetch loop feeding four shifters, one pixel per cycle.
module ppu_bg_fetcher
    import ppu_pkg::*;
#(
    parameter int NUM_PIXELS    = 256,
    parameter int PRELOAD_TILES = 2
) (
    input  logic        ppu_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [14:0] start_v,
    input  logic [2:0]  fine_x,
    input  logic        bg_table,
    output logic [15:0] ppu_ab,
    input  logic [7:0]  ppu_do,
    output logic [3:0]  pixel,
    output logic        pixel_valid,
    output logic        busy,
    output logic        done
);

    localparam int RENDER_TILES = NUM_PIXELS / 8;
    localparam int TW           = $clog2(RENDER_TILES + PRELOAD_TILES + 1);

    bg_state_t     state;
    logic [2:0]    phase;
    logic [TW-1:0] tile_cnt;
    logic [14:0]   v;
    logic [2:0]    fine_x_q;
    logic          bg_table_q;
    logic [7:0]    tile_id;
    logic [1:0]    pal;
    logic [7:0]    pt_lo;
    logic          last_tile;

    logic [15:0]   sr_pt_lo, sr_pt_hi, sr_pal_lo, sr_pal_hi;
    logic          sh_load, sh_preload, sh_shift;
    logic [3:0]    bit_sel;

    assign last_tile = (state == PRELOAD) ? (tile_cnt == TW'(PRELOAD_TILES - 1))
                                          : (tile_cnt == TW'(RENDER_TILES - 1));

    // start is taken only while idle (busy low); busy covers the whole line, done pulses once after
    always_ff @(posedge ppu_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 3'd0;
            tile_cnt    <= '0;
            v           <= 15'd0;
            fine_x_q    <= 3'd0;
            bg_table_q  <= 1'b0;
            tile_id     <= 8'd0;
            pal         <= 2'd0;
            pt_lo       <= 8'd0;
            ppu_ab      <= 16'd0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ppu_ab <= 16'd0;
                    if (start) begin
                        v          <= start_v;
                        fine_x_q   <= fine_x;
                        bg_table_q <= bg_table;
                        phase      <= 3'd0;
                        tile_cnt   <= '0;
                        ppu_ab     <= nt_addr(start_v);
                        busy       <= 1'b1;
                        state      <= PRELOAD;
                    end
                end
                default: begin
                    phase <= phase + 3'd1;
                    // ppu_ab is set one cycle ahead for the phase that follows
                    case (phase)
                        3'd1: begin
                            tile_id <= ppu_do;
                            ppu_ab  <= at_addr(v);
                        end
                        3'd3: begin
                            pal    <= at_select(ppu_do, v);
                            ppu_ab <= pt_addr(bg_table_q, tile_id, 1'b0, v);
                        end
                        3'd5: begin
                            pt_lo  <= ppu_do;
                            ppu_ab <= pt_addr(bg_table_q, tile_id, 1'b1, v);
                        end
                        3'd7: begin
                            v        <= coarse_x_inc(v);
                            ppu_ab   <= nt_addr(coarse_x_inc(v));
                            tile_cnt <= tile_cnt + 1'b1;
                            if (last_tile) begin
                                tile_cnt <= '0;
                                if (state == PRELOAD) begin
                                    state       <= RENDER;
                                    pixel_valid <= 1'b1;
                                end else begin
                                    state       <= IDLE;
                                    pixel_valid <= 1'b0;
                                    busy        <= 1'b0;
                                    done        <= 1'b1;
                                    ppu_ab      <= 16'd0;
                                end
                            end
                        end
                        default: ppu_ab <= 16'd0;
                    endcase
                end
            endcase
        end
    end

    assign sh_load    = (state != IDLE) && (phase == 3'd7);
    assign sh_preload = (state == PRELOAD);
    assign sh_shift   = (state == RENDER);

    ppu_bg_shifter u_sr_pt_lo (
        .clk(ppu_clk), .rst_n(rst_n), .load(sh_load), .preload(sh_preload),
        .shift(sh_shift), .din(pt_lo), .q(sr_pt_lo)
    );

    ppu_bg_shifter u_sr_pt_hi (
        .clk(ppu_clk), .rst_n(rst_n), .load(sh_load), .preload(sh_preload),
        .shift(sh_shift), .din(ppu_do), .q(sr_pt_hi)
    );

    ppu_bg_shifter u_sr_pal_lo (
        .clk(ppu_clk), .rst_n(rst_n), .load(sh_load), .preload(sh_preload),
        .shift(sh_shift), .din({8{pal[0]}}), .q(sr_pal_lo)
    );

    ppu_bg_shifter u_sr_pal_hi (
        .clk(ppu_clk), .rst_n(rst_n), .load(sh_load), .preload(sh_preload),
        .shift(sh_shift), .din({8{pal[1]}}), .q(sr_pal_hi)
    );

    assign bit_sel = 4'd15 - {1'b0, fine_x_q};
    assign pixel   = pixel_valid ? {sr_pal_hi[bit_sel], sr_pal_lo[bit_sel],
                                    sr_pt_hi[bit_sel], sr_pt_lo[bit_sel]} : 4'd0;

endmodule
